// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment encodings, BCD decode function and scan state enum
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } scan_state_t;

  // Non-BCD codes decode to a dark digit rather than a garbage pattern.
  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg7 = SEG7_0;
      4'd1:    seg7 = SEG7_1;
      4'd2:    seg7 = SEG7_2;
      4'd3:    seg7 = SEG7_3;
      4'd4:    seg7 = SEG7_4;
      4'd5:    seg7 = SEG7_5;
      4'd6:    seg7 = SEG7_6;
      4'd7:    seg7 = SEG7_7;
      4'd8:    seg7 = SEG7_8;
      4'd9:    seg7 = SEG7_9;
      default: seg7 = SEG7_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit multiplexed 7-segment scanner with per-frame snapshot, PWM brightness and dark guard
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DPN = 1024,
  parameter int BPN = 64,
  parameter int DPL = $clog2(DPN)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_0,
  input  logic [6:0] seg_1,
  input  logic [6:0] seg_2,
  input  logic [6:0] seg_3,
  input  logic [3:0] blank,
  input  logic [2:0] bright,
  output logic [6:0] seg_o,
  output logic [3:0] dig_o,
  output logic       frame
);

  if ((DPN < 2) || ((DPN & (DPN - 1)) != 0)) begin : g_bad_dpn
    $error("seg7_scan: DPN must be a power of two");
  end
  if (BPN >= DPN) begin : g_bad_bpn
    $error("seg7_scan: BPN must be smaller than DPN");
  end
  if (((DPN - BPN) % 8) != 0) begin : g_bad_div
    $error("seg7_scan: DPN-BPN must be divisible by 8");
  end

  localparam logic [DPL+2:0] WIDE_ONE = (DPL+3)'(1);
  localparam logic [DPL+2:0] ON_UNIT  = (DPL+3)'((DPN - BPN) / 8);
  localparam logic [DPL-1:0] CNT_ONE  = DPL'(1);
  localparam logic [DPL-1:0] CNT_LAST = DPL'(DPN - 1);

  scan_state_t    r_state;
  logic [6:0]     r_seg [4];
  logic [3:0]     r_blank;
  logic [DPL-1:0] r_on_len;
  logic [DPL-1:0] r_cnt;
  logic [1:0]     r_idx;

  logic [DPL+2:0] w_bright_ext;
  logic [DPL+2:0] w_on_wide;
  logic [DPL-1:0] w_on_len;
  logic [1:0]     w_idx_next;

  // Lit length for the incoming snapshot: (bright+1) eighths of the non-guard part of the slot.
  assign w_bright_ext = {{DPL{1'b0}}, bright};
  assign w_on_wide    = (w_bright_ext + WIDE_ONE) * ON_UNIT;
  assign w_on_len     = w_on_wide[DPL-1:0];
  assign w_idx_next   = r_idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_seg[0] <= 7'h00;
      r_seg[1] <= 7'h00;
      r_seg[2] <= 7'h00;
      r_seg[3] <= 7'h00;
      r_blank  <= 4'h0;
      r_on_len <= '0;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      seg_o    <= 7'h00;
      dig_o    <= 4'h0;
      frame    <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (!en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_idx   <= 2'd0;
        seg_o   <= 7'h00;
        dig_o   <= 4'h0;
      end else begin
        case (r_state)
          IDLE, OFF: begin
            if (r_state == IDLE || r_cnt == CNT_LAST) begin
              r_state <= ON;
              r_cnt   <= '0;
              if (r_state == IDLE || r_idx == 2'd3) begin
                // Frame boundary: snapshot live inputs and show digit 0 from them directly.
                r_seg[0] <= seg_0;
                r_seg[1] <= seg_1;
                r_seg[2] <= seg_2;
                r_seg[3] <= seg_3;
                r_blank  <= blank;
                r_on_len <= w_on_len;
                r_idx    <= 2'd0;
                frame    <= 1'b1;
                seg_o    <= blank[0] ? 7'h00 : seg_0;
                dig_o    <= blank[0] ? 4'h0 : 4'b0001;
              end else begin
                r_idx <= w_idx_next;
                seg_o <= r_blank[w_idx_next] ? 7'h00 : r_seg[w_idx_next];
                dig_o <= r_blank[w_idx_next] ? 4'h0 : (4'b0001 << w_idx_next);
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              seg_o <= 7'h00;
              dig_o <= 4'h0;
            end
          end
          ON: begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == r_on_len - CNT_ONE) begin
              r_state <= OFF;
              seg_o   <= 7'h00;
              dig_o   <= 4'h0;
            end
          end
          default: begin
            r_state <= IDLE;
            seg_o   <= 7'h00;
            dig_o   <= 4'h0;
          end
        endcase
      end
    end
  end

endmodule
